// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed digit scanner with PWM brightness, frame-coherent data snapshot and hex decode.
// Optional leading-zero blanking is compiled in when SCAN_LZ_BLANK_EN is defined.
module digit_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_TICKS  = 31_250
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [3:0]              brightness,
    input  logic                    enable,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [3:0]              noteKey,
    output logic [2:0]              scan_idx,
    output logic                    frame_tick
);

    localparam int DIV_W = $clog2(DIV_TICKS);

    logic [DIV_W-1:0]        div;
    logic [3:0]              phase;
    logic [2:0]              idx;
    logic [3:0]              slot_bright;
    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic                    loaded;

    logic                    div_term;
    logic                    phase_wrap;
    logic                    idx_wrap;
    logic [3:0]              cur_key;
    logic                    cur_dp;
    logic                    cur_upper_zero;
    logic                    blank_now;
    logic [NUM_DIGITS-1:0]   an_next;

    assign div_term   = (div == DIV_W'(DIV_TICKS - 1));
    assign phase_wrap = div_term && (phase == 4'd15);
    assign idx_wrap   = phase_wrap && (idx == 3'(NUM_DIGITS - 1));

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Select the current slot's snapshot data and its anode; upper_zero means digits idx..top are all 0.
    always_comb begin
        cur_key        = 4'd0;
        cur_dp         = 1'b0;
        cur_upper_zero = 1'b0;
        an_next        = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == 3'(i)) begin
                cur_key        = snap_digits[4*i +: 4];
                cur_dp         = snap_dp[i];
                cur_upper_zero = ((snap_digits >> (4*i)) == '0);
                if (enable && (phase <= slot_bright))
                    an_next[i] = 1'b0;
            end
        end
    end

`ifdef SCAN_LZ_BLANK_EN
    assign blank_now = blank_lz && (idx != 3'd0) && cur_upper_zero;
`else
    logic lz_unused;
    assign lz_unused = blank_lz ^ cur_upper_zero;
    assign blank_now = 1'b0;
`endif

    // Counters, snapshot capture and all display outputs update together so anode and segments never skew.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div         <= '0;
            phase       <= 4'd0;
            idx         <= 3'd0;
            slot_bright <= 4'd0;
            snap_digits <= '0;
            snap_dp     <= '0;
            loaded      <= 1'b0;
            an          <= '1;
            seg         <= 7'b1111111;
            dp          <= 1'b1;
            noteKey     <= 4'd0;
            scan_idx    <= 3'd0;
            frame_tick  <= 1'b0;
        end else begin
            loaded <= 1'b1;
            div    <= div_term ? '0 : div + 1'b1;
            if (div_term)
                phase <= phase + 4'd1;
            if (phase_wrap)
                idx <= idx_wrap ? 3'd0 : idx + 3'd1;
            frame_tick <= idx_wrap;
            if (!loaded || idx_wrap) begin
                snap_digits <= digits;
                snap_dp     <= dp_in;
            end
            if (!loaded || phase_wrap)
                slot_bright <= brightness;
            an       <= an_next;
            seg      <= blank_now ? 7'b1111111 : hex_to_seg(cur_key);
            dp       <= ~cur_dp;
            noteKey  <= cur_key;
            scan_idx <= idx;
        end
    end

endmodule
